spi_calc_master: RTL and testbench
==================================

# spi_calc_master

Initiator end of the calculator SPI link. It takes a parallel request (operand A, operand B, opcode) from the host-side logic. It serialises the request MSB-first on MOSI under an active-low CS, one bit per clk_arduino cycle, with a leading handshake bit. It optionally reads a 4-bit result back on MISO and presents it in parallel. It sits on the Arduino/test side, facing the calculator slave, and shares the slave's bit clock.

## Interface
- OP_W, default 4: width of operand A, operand B, opcode and result.
- GAP_CYCLES, default 5: minimum number of cycles CS stays high between frames.

Ports:
- clk_arduino  in  1  single clock; also the link bit clock.
- reset  in  1  asynchronous, active-low.
- start  in  1  request a frame; sampled only when busy=0.
- operand_a  in  OP_W  first operand; latched at accepted start.
- operand_b  in  OP_W  second operand; latched at accepted start.
- opcode  in  OP_W  operator code; latched at accepted start.
- busy  out  1  high from the cycle after an accepted start until the gap ends.
- done  out  1  one-cycle pulse at frame end.
- result  out  OP_W  last read-back value; held until the next done.
- MOSI  out  1  serial data to the slave.
- CS  out  1  active-low chip select.
- MISO  in  1  serial data from the slave.

## Operation
- Frame on MOSI: handshake bit '1', then operand_a[OP_W-1:0], then operand_b, then opcode. All fields are MSB-first, with CS=0 for all 1+3·OP_W bits (13 at default).
- Readback phase (macro enabled): after the opcode LSB, CS stays low for OP_W more cycles with MOSI=0. MISO is shifted in MSB-first.
- State machine:
  - IDLE: waits for start.
  - HANDSHAKE: 1 cycle.
  - SHIFT: 3·OP_W cycles, counted down by a bit counter.
  - READ: OP_W cycles; present only with the macro.
  - GAP: GAP_CYCLES cycles with CS=1, then back to IDLE.
- Transitions are unconditional once started; start is ignored while busy.
- Operands are captured into a 3·OP_W shift register at accept, so input changes mid-frame have no effect.
- Reset values: CS=1, MOSI=0, busy=0, done=0, result=0, state IDLE, counters 0.
- Reset asserted mid-frame: CS returns high and MOSI goes low asynchronously. No partial result is committed and done does not pulse.
- start held high continuously: frames repeat back-to-back, separated by exactly GAP_CYCLES cycles of CS high.
- MISO value while CS=1 is don't-care and never sampled.

## Timing
- All outputs are registered and launch on the rising edge of clk_arduino. The slave samples on the next rising edge.
- Edge 0: start=1 and busy=0 are sampled.
- Edge 1: CS=0, MOSI=1 (handshake), busy=1.
- Edges 2..13: data bits 11..0 on MOSI.
- With readback: edges 14..17 are read cycles. The master samples MISO at edges 15..18, bit OP_W-1 first.
- At edge 18: CS=1, result updated, done=1 for one cycle.
- Without readback: at edge 14, CS=1 and done=1; result is unchanged.
- busy falls GAP_CYCLES cycles after done rises. A start on that same edge is accepted.
- Start-to-done latency: 18 cycles with readback, 14 without (default widths).

## Configuration
- SPI_MASTER_READBACK_EN defined: READ state present, result driven from MISO, frame length 1+4·OP_W.
- Not defined: no READ state, MISO unused, result tied to 0, frame length 1+3·OP_W, done at the edge CS rises after the opcode LSB.

## Structure
- Package spi_calc_pkg holds:
  - OP_W default and FRAME_BITS = 1+3·OP_W.
  - HANDSHAKE_BIT = 1'b1.
  - The state enum (IDLE, HANDSHAKE, SHIFT, READ, GAP).
  - Opcode constants shared with the slave.
- One sub-module, spi_tx_shifter: a parallel-load, MSB-first shift register with a bit-count-done flag. Instantiated once for TX; the RX side is a plain OP_W shift in the top.

## Test plan
- Reset low at time 0, then high: CS=1, MOSI=0, busy=0, result=0 until the first start.
- start with A=4'b1100, B=4'b0110, op=4'b1100: MOSI reads 1,1100,0110,1100 over 13 consecutive cycles with CS=0. busy rises at edge 1.
- Readback enabled, slave model drives 4'b0110 on MISO during the read cycles: result=4'b0110 and done pulses once at edge 18. CS is then high for 5 cycles.
- start held high with A=4'b1011: the second frame's handshake appears exactly 5 cycles after the first CS rise. Inputs changed mid-frame do not alter the MOSI bits.
- reset pulsed low during SHIFT bit 6: CS=1 and MOSI=0 immediately, no done pulse, result unchanged at 0. A new start afterwards produces a complete frame.
- Macro undefined, same stimulus as the second scenario: CS rises at edge 14, done is at edge 14, and result stays 0.

Source files
------------

// File: rtl/spi_calc_pkg.sv
// Shared definitions for the calculator SPI link: default widths, frame constants,
// master FSM states and the opcode set understood by the calculator slave.
package spi_calc_pkg;

  localparam int   DEF_OP_W      = 4;
  localparam int   FRAME_BITS    = 1 + 3 * DEF_OP_W;
  localparam logic HANDSHAKE_BIT = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    HANDSHAKE,
    SHIFT,
    READ,
    GAP
  } state_t;

  typedef enum logic [DEF_OP_W-1:0] {
    OPC_ADD = 4'd0,
    OPC_SUB = 4'd1,
    OPC_MUL = 4'd2,
    OPC_AND = 4'd3,
    OPC_OR  = 4'd4,
    OPC_XOR = 4'd5
  } opcode_t;

endpackage

// File: rtl/spi_tx_shifter.sv
// Parallel-load, MSB-first shift register with a bit counter; o_done is high once
// every loaded bit has been shifted out.
module spi_tx_shifter #(
  parameter int W = 12
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_data,
  input  logic         i_shift,
  output logic         o_msb,
  output logic         o_done
);

  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  r_data;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_data <= '0;
      r_cnt  <= '0;
    end else if (i_load) begin
      r_data <= i_data;
      r_cnt  <= CW'(W);
    end else if (i_shift) begin
      r_data <= {r_data[W-2:0], 1'b0};
      r_cnt  <= r_cnt - 1'b1;
    end
  end

  assign o_msb  = r_data[W-1];
  assign o_done = (r_cnt == '0);

endmodule

// File: rtl/spi_calc_master.sv
// SPI initiator for the calculator link: handshake bit, A/B/opcode MSB-first under CS low,
// then a CS-high gap. Define SPI_MASTER_READBACK_EN to add the OP_W-bit MISO readback phase.
module spi_calc_master
  import spi_calc_pkg::*;
#(
  parameter int OP_W       = DEF_OP_W,
  parameter int GAP_CYCLES = 5
) (
  input  logic            clk_arduino,
  input  logic            reset,
  input  logic            start,
  input  logic [OP_W-1:0] operand_a,
  input  logic [OP_W-1:0] operand_b,
  input  logic [OP_W-1:0] opcode,
  output logic            busy,
  output logic            done,
  output logic [OP_W-1:0] result,
  output logic            MOSI,
  output logic            CS,
  input  logic            MISO,
  output state_t          o_dbg_state
);

  localparam int TX_W    = 3 * OP_W;
  localparam int CNT_MAX = (GAP_CYCLES > OP_W) ? GAP_CYCLES : OP_W;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             w_tx_load;
  logic             w_tx_shift;
  logic             w_tx_msb;
  logic             w_tx_done;

  // A start seen on the last gap cycle chains straight into the next handshake.
  assign w_tx_load  = start && ((r_state == IDLE) || ((r_state == GAP) && (r_cnt == '0)));
  assign w_tx_shift = (r_state == HANDSHAKE) || ((r_state == SHIFT) && !w_tx_done);

  spi_tx_shifter #(.W(TX_W)) u_tx (
    .i_clk   (clk_arduino),
    .i_rst_n (reset),
    .i_load  (w_tx_load),
    .i_data  ({operand_a, operand_b, opcode}),
    .i_shift (w_tx_shift),
    .o_msb   (w_tx_msb),
    .o_done  (w_tx_done)
  );

  always_ff @(posedge clk_arduino or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      CS      <= 1'b1;
      MOSI    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_tx_load) begin
            r_state <= HANDSHAKE;
            CS      <= 1'b0;
            MOSI    <= HANDSHAKE_BIT;
            busy    <= 1'b1;
          end
        end
        HANDSHAKE: begin
          r_state <= SHIFT;
          MOSI    <= w_tx_msb;
        end
        SHIFT: begin
          if (!w_tx_done) begin
            MOSI <= w_tx_msb;
          end else begin
            MOSI <= 1'b0;
`ifdef SPI_MASTER_READBACK_EN
            r_state <= READ;
            r_cnt   <= CNT_W'(OP_W - 1);
`else
            r_state <= GAP;
            CS      <= 1'b1;
            done    <= 1'b1;
            r_cnt   <= CNT_W'(GAP_CYCLES - 1);
`endif
          end
        end
`ifdef SPI_MASTER_READBACK_EN
        READ: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_state <= GAP;
            CS      <= 1'b1;
            done    <= 1'b1;
            r_cnt   <= CNT_W'(GAP_CYCLES - 1);
          end
        end
`endif
        GAP: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else if (w_tx_load) begin
            r_state <= HANDSHAKE;
            CS      <= 1'b0;
            MOSI    <= HANDSHAKE_BIT;
          end else begin
            r_state <= IDLE;
            busy    <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef SPI_MASTER_READBACK_EN
  logic [OP_W-2:0] r_rx;
  logic [OP_W-1:0] w_rx_next;

  assign w_rx_next = {r_rx, MISO};

  // The final sample goes straight into result so it lands together with done.
  always_ff @(posedge clk_arduino or negedge reset) begin
    if (!reset) begin
      r_rx   <= '0;
      result <= '0;
    end else if (r_state == READ) begin
      r_rx <= w_rx_next[OP_W-2:0];
      if (r_cnt == '0) begin
        result <= w_rx_next;
      end
    end
  end
`else
  wire w_unused_miso = MISO;

  assign result = '0;
`endif

  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_spi_calc_master.sv
// Randomised self-checking bench for spi_calc_master; expected waveforms come from the
// frame rules (bit lists, frame length, gap length), built per frame in a queue.
`timescale 1ns/1ps
module tb_spi_calc_master;
  import spi_calc_pkg::*;

  localparam int OP_W = 4;
  localparam int GAP  = 5;
`ifdef SPI_MASTER_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif
  localparam int FL = 1 + 3 * OP_W + (RB ? OP_W : 0);

  logic            clk;
  logic            reset;
  logic            start;
  logic [OP_W-1:0] operand_a;
  logic [OP_W-1:0] operand_b;
  logic [OP_W-1:0] opcode;
  logic            busy;
  logic            done;
  logic [OP_W-1:0] result;
  logic            MOSI;
  logic            CS;
  logic            MISO;
  state_t          dbg_state;

  int n_chk = 0;
  int n_err = 0;
  logic [OP_W-1:0] exp_result;

  spi_calc_master #(.OP_W(OP_W), .GAP_CYCLES(GAP)) dut (
    .clk_arduino (clk),
    .reset       (reset),
    .start       (start),
    .operand_a   (operand_a),
    .operand_b   (operand_b),
    .opcode      (opcode),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .MOSI        (MOSI),
    .CS          (CS),
    .MISO        (MISO),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_cs"},    32'(CS),   32'(1));
    check({tag, "_mosi"},  32'(MOSI), 32'(0));
    check({tag, "_busy"},  32'(busy), 32'(0));
    check({tag, "_done"},  32'(done), 32'(0));
    check({tag, "_result"}, 32'(result), 32'(exp_result));
  endtask

  // Drives one frame starting at a negedge and checks every cycle until busy drops
  // (or, with hold, until the last gap cycle so the next frame chains on).
  task automatic do_frame(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b,
                          input logic [OP_W-1:0] op, input logic [OP_W-1:0] miso_val,
                          input bit hold);
    logic [0:0] exp_q[$];
    int last;
    exp_q = {};
    exp_q.push_back(1'b1);
    for (int i = OP_W - 1; i >= 0; i--) exp_q.push_back(a[i]);
    for (int i = OP_W - 1; i >= 0; i--) exp_q.push_back(b[i]);
    for (int i = OP_W - 1; i >= 0; i--) exp_q.push_back(op[i]);
    if (RB) for (int i = 0; i < OP_W; i++) exp_q.push_back(1'b0);
    operand_a = a;
    operand_b = b;
    opcode    = op;
    start     = 1'b1;
    last = hold ? FL + GAP : FL + GAP + 1;
    for (int k = 1; k <= last; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k <= FL) begin
        check("frame_cs",   32'(CS),   32'(0));
        check("frame_mosi", 32'(MOSI), 32'(exp_q.pop_front()));
        check("frame_done", 32'(done), 32'(0));
        check("frame_busy", 32'(busy), 32'(1));
      end else if (k == FL + 1) begin
        exp_result = RB ? miso_val : exp_result;
        check("end_cs",   32'(CS),   32'(1));
        check("end_mosi", 32'(MOSI), 32'(0));
        check("end_done", 32'(done), 32'(1));
        check("end_busy", 32'(busy), 32'(1));
      end else if (k <= FL + GAP) begin
        check("gap_cs",   32'(CS),   32'(1));
        check("gap_mosi", 32'(MOSI), 32'(0));
        check("gap_done", 32'(done), 32'(0));
        check("gap_busy", 32'(busy), 32'(1));
      end else begin
        check("idle_cs",   32'(CS),   32'(1));
        check("idle_busy", 32'(busy), 32'(0));
        check("idle_done", 32'(done), 32'(0));
      end
      check("result", 32'(result), 32'(exp_result));
      if (!hold) start = 1'b0;
      if (k < FL) begin
        operand_a = OP_W'($urandom);
        operand_b = OP_W'($urandom);
        opcode    = OP_W'($urandom);
      end
      if (RB && k >= FL - OP_W + 1 && k <= FL) MISO = miso_val[FL - k];
      else MISO = 1'($urandom_range(0, 1));
    end
  endtask

  initial begin
    reset      = 1'b0;
    start      = 1'b0;
    operand_a  = '0;
    operand_b  = '0;
    opcode     = '0;
    MISO       = 1'b0;
    exp_result = '0;

    repeat (3) @(negedge clk);
    check_idle("rst");
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_idle("post_rst");

    // directed frame from the test plan
    do_frame(4'b1100, 4'b0110, 4'b1100, 4'b0110, 1'b0);

    // isolated random frames with random idle spacing
    for (int i = 0; i < 6; i++) begin
      do_frame(OP_W'($urandom), OP_W'($urandom), OP_W'($urandom), OP_W'($urandom), 1'b0);
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        check_idle("between");
      end
    end

    // start held high: frames chain after exactly GAP cycles of CS high
    do_frame(4'b1011, OP_W'($urandom), OP_W'($urandom), OP_W'($urandom), 1'b1);
    do_frame(OP_W'($urandom), OP_W'($urandom), OP_W'($urandom), OP_W'($urandom), 1'b1);
    do_frame(OP_W'($urandom), OP_W'($urandom), OP_W'($urandom), OP_W'($urandom), 1'b0);

    // reset while data bit 6 is on MOSI
    operand_a = OP_W'($urandom);
    operand_b = OP_W'($urandom);
    opcode    = OP_W'($urandom);
    start     = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("pre_rst_cs", 32'(CS), 32'(0));
    #1 reset = 1'b0;
    exp_result = '0;
    #1;
    check_idle("async_rst");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("after_rst_done", 32'(done), 32'(0));
      check("after_rst_cs",   32'(CS),   32'(1));
    end
    check("after_rst_result", 32'(result), 32'(exp_result));
    do_frame(OP_W'($urandom), OP_W'($urandom), OP_W'($urandom), OP_W'($urandom), 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
